// File: rtl/rnd_pkg.sv
// ---------------------------------------------------------------------------
// rnd_pkg
//   Shared types and constants for the serial random-bit source.
//   - rnd_state_t  : frame FSM states
//   - LFSR_W       : LFSR width
//   - LFSR_TAPS    : feedback taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   - LFSR_MSB     : mask selecting the bit shifted out as the frame bit
//   - DEFAULT_SEED : reset / zero-load substitute seed
// ---------------------------------------------------------------------------
package rnd_pkg;

   localparam int unsigned        LFSR_W       = 16;
   localparam logic [LFSR_W-1:0]  LFSR_TAPS    = 16'hB400;
   localparam logic [LFSR_W-1:0]  LFSR_MSB     = 16'h8000;
   localparam logic [LFSR_W-1:0]  DEFAULT_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } rnd_state_t;

endpackage

// File: rtl/rnd_bit_gen_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
//   Free-running 16-bit Fibonacci LFSR, shifting toward the MSB.
//   Ports:
//     clk  in   rising-edge clock
//     rst  in   asynchronous active-high reset (q <= SEED)
//     ld   in   load din instead of advancing on this edge
//     din  in   load value; zero is replaced by SEED so the register
//               can never lock up at all-zero
//     q    out  current LFSR state
// ---------------------------------------------------------------------------
module lfsr16
   import rnd_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld,
   input  logic [LFSR_W-1:0] din,
   output logic [LFSR_W-1:0] q
);

   logic fb;

   always_comb fb = ^(q & LFSR_TAPS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= SEED;
      end else if (ld) begin
         q <= (din == '0) ? SEED : din;
      end else begin
         q <= {q[LFSR_W-2:0], fb};
      end
   end

endmodule

// File: rtl/rnd_bit_gen.sv
// ---------------------------------------------------------------------------
// rnd_bit_gen
//   On a start request, emits one FRAME_LEN-bit frame of pseudo-random bits,
//   MSB first, one per clock, taken from a free-running LFSR.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     start      frame request, honoured only in IDLE
//     seed_ld    load seed into the LFSR, honoured only in IDLE
//     seed       seed value
//     rndbt      registered serial frame bit (0 outside frames)
//     vld        rndbt carries a frame bit
//     frm_start  pulse with the first frame bit
//     frm_done   pulse in the cycle after the last frame bit
//     busy       FSM not in IDLE
//     ones       count of 1s in the frame, final while frm_done is high
// ---------------------------------------------------------------------------
module rnd_bit_gen
   import rnd_pkg::*;
#(
   parameter int unsigned       FRAME_LEN = 8,
   parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               seed_ld,
   input  logic [LFSR_W-1:0]                  seed,
   output logic                               rndbt,
   output logic                               vld,
   output logic                               frm_start,
   output logic                               frm_done,
   output logic                               busy,
   output logic [$clog2(FRAME_LEN+1)-1:0]     ones
);

   localparam int unsigned CW = $clog2(FRAME_LEN + 1);

   rnd_state_t        state, state_nxt;
   logic [CW-1:0]     bit_cnt;
   logic [LFSR_W-1:0] lfsr_q;
   logic              lfsr_ld;
   logic              frame_bit;
   logic              last_bit;

   // Seed loads are only honoured while idle; otherwise the LFSR keeps running.
   always_comb lfsr_ld = seed_ld && (state == IDLE);

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .ld  (lfsr_ld),
      .din (seed),
      .q   (lfsr_q)
   );

   always_comb frame_bit = |(lfsr_q & LFSR_MSB);
   always_comb last_bit  = (bit_cnt == CW'(FRAME_LEN - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb busy = (state != IDLE);

   // Strobes default low each edge so they form single-cycle pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rndbt     <= 1'b0;
         vld       <= 1'b0;
         frm_start <= 1'b0;
         frm_done  <= 1'b0;
         bit_cnt   <= '0;
         ones      <= '0;
      end else begin
         rndbt     <= 1'b0;
         vld       <= 1'b0;
         frm_start <= 1'b0;
         frm_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bit_cnt <= '0;
                  ones    <= '0;
               end
            end
            RUN: begin
               rndbt     <= frame_bit;
               vld       <= 1'b1;
               frm_start <= (bit_cnt == '0);
               bit_cnt   <= bit_cnt + CW'(1);
               ones      <= ones + {{(CW-1){1'b0}}, frame_bit};
            end
            DONE: begin
               frm_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rnd_bit_gen.sv
// ---------------------------------------------------------------------------
// tb_rnd_bit_gen
//   Self-checking bench for rnd_bit_gen (FRAME_LEN = 8).
// ---------------------------------------------------------------------------
module tb_rnd_bit_gen;

   localparam int unsigned FL      = 8;
   localparam int unsigned CW      = $clog2(FL + 1);
   localparam logic [15:0] TB_SEED = 16'hACE1;

   logic          clk       = 1'b0;
   logic          rst       = 1'b0;
   logic          start     = 1'b0;
   logic          seed_ld   = 1'b0;
   logic [15:0]   seed      = '0;
   logic          rndbt;
   logic          vld;
   logic          frm_start;
   logic          frm_done;
   logic          busy;
   logic [CW-1:0] ones;

   rnd_bit_gen #(.FRAME_LEN(FL), .SEED(TB_SEED)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .seed_ld   (seed_ld),
      .seed      (seed),
      .rndbt     (rndbt),
      .vld       (vld),
      .frm_start (frm_start),
      .frm_done  (frm_done),
      .busy      (busy),
      .ones      (ones)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic b;
      logic first;
   } exp_bit_t;

   typedef struct {
      logic [15:0]   seed;
      logic [FL-1:0] bits;
      int            ones;
   } vec_t;

   exp_bit_t    exp_q[$];
   int          exp_ones_q[$];
   int          fs_cyc_q[$];
   exp_bit_t    mon_e;
   int          checks   = 0;
   int          errors   = 0;
   int          done_cnt = 0;
   int          cyc      = 0;
   logic        m_ld     = 1'b0;
   logic [15:0] mq;
   vec_t        tbl[3];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference LFSR; m_ld is asserted only when the bench knows the DUT is idle.
   function automatic logic [15:0] step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst)       mq <= TB_SEED;
      else if (m_ld) mq <= (seed == 16'h0) ? TB_SEED : seed;
      else           mq <= step(mq);
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: pops the scoreboard for every valid bit.
   always @(negedge clk) begin
      if (vld) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_vld", vld, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rndbt", rndbt, mon_e.b);
            chk("frm_start", frm_start, mon_e.first);
            if (mon_e.first) fs_cyc_q.push_back(cyc);
         end
      end else begin
         chk("idle_rndbt", rndbt, 0);
         chk("idle_frm_start", frm_start, 0);
      end
      if (frm_done) begin
         done_cnt++;
         chk("done_busy", busy, 0);
         chk("done_bits_left", exp_q.size(), 0);
         if (exp_ones_q.size() == 0) chk("unexpected_done", frm_done, 0);
         else                        chk("ones", ones, exp_ones_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_bits(input logic [FL-1:0] b, input int n1);
      exp_bit_t e;
      for (int i = 0; i < FL; i++) begin
         e.b     = b[FL-1-i];
         e.first = (i == 0);
         exp_q.push_back(e);
      end
      exp_ones_q.push_back(n1);
   endtask

   task automatic push_model_frame();
      logic [15:0]   t;
      logic [FL-1:0] b;
      int            n1;
      t  = mq;
      n1 = 0;
      for (int i = 0; i < FL; i++) begin
         b[FL-1-i] = t[15];
         n1 += int'(t[15]);
         t = step(t);
      end
      push_bits(b, n1);
   endtask

   task automatic start_frame(input logic [15:0] s, input logic ld);
      start   = 1'b1;
      seed_ld = ld;
      m_ld    = ld;
      seed    = s;
      tick();
      start   = 1'b0;
      seed_ld = 1'b0;
      m_ld    = 1'b0;
   endtask

   task automatic wait_done(input int target, input string name);
      for (int i = 0; i < 40 && done_cnt < target; i++) tick();
      chk(name, done_cnt, target);
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_rndbt"}, rndbt, 0);
      chk({pfx, "_vld"}, vld, 0);
      chk({pfx, "_frm_start"}, frm_start, 0);
      chk({pfx, "_frm_done"}, frm_done, 0);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_ones"}, ones, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;

      tbl[0] = '{seed: 16'h6000, bits: 8'b0110_0000, ones: 2};
      tbl[1] = '{seed: 16'hB400, bits: 8'b1011_0100, ones: 4};
      tbl[2] = '{seed: 16'h0000, bits: 8'b1010_1100, ones: 4};

      // Asynchronous reset before any clock edge.
      #2 rst = 1'b1;
      #1;
      chk_all_zero("reset");
      tick();
      tick();
      rst = 1'b0;
      repeat (3) tick();

      // Unseeded frame: checks reset seed and free-running advance.
      base = done_cnt;
      start_frame(16'h0, 1'b0);
      push_model_frame();
      wait_done(base + 1, "done_unseeded");
      tick();

      // Seeded frames from the table.
      for (int i = 0; i < 3; i++) begin
         base = done_cnt;
         start_frame(tbl[i].seed, 1'b1);
         push_bits(tbl[i].bits, tbl[i].ones);
         wait_done(base + 1, "done_tbl");
         tick();
      end

      // start / seed_ld while busy are ignored.
      base = done_cnt;
      start_frame(16'h6000, 1'b1);
      push_bits(8'b0110_0000, 2);
      tick();
      tick();
      start = 1'b1; seed_ld = 1'b1; seed = 16'hFFFF;
      tick();
      start = 1'b0; seed_ld = 1'b0;
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("ign_one_done", done_cnt, base + 1);
      repeat (12) tick();
      chk("ign_no_second_frame", done_cnt, base + 1);
      chk("ign_q_empty", exp_q.size(), 0);

      // LFSR must not have taken the mid-frame seed.
      base = done_cnt;
      start_frame(16'hFFFF, 1'b0);
      push_model_frame();
      wait_done(base + 1, "done_after_ignored_ld");
      tick();

      // Reset mid-frame after bit 4.
      base = done_cnt;
      start_frame(16'h6000, 1'b1);
      push_bits(8'b0110_0000, 2);
      repeat (4) tick();
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_all_zero("midrst");
      exp_q.delete();
      exp_ones_q.delete();
      tick();
      tick();
      rst = 1'b0;
      repeat (12) tick();
      chk("midrst_no_done", done_cnt, base);
      base = done_cnt;
      start_frame(16'h6000, 1'b1);
      push_bits(8'b0110_0000, 2);
      wait_done(base + 1, "done_after_rst");
      tick();

      // Back-to-back frames with start held high.
      fs_cyc_q.delete();
      base  = done_cnt;
      start = 1'b1;
      for (int f = 0; f < 3; f++) begin
         tick();
         push_model_frame();
         if (f < 2) repeat (FL + 1) tick();
      end
      start = 1'b0;
      wait_done(base + 3, "done_b2b");
      chk("b2b_frames", fs_cyc_q.size(), 3);
      for (int i = 1; i < fs_cyc_q.size(); i++) begin
         chk("b2b_spacing", fs_cyc_q[i] - fs_cyc_q[i-1], FL + 2);
      end
      repeat (4) tick();
      chk("b2b_q_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
